// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt vector fetch master: bus encodings,
// interrupt controller register offsets, FSM state types, the request payload
// handed to the AHB single-transfer engine, and small address helpers.
package irq_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = 6;
   localparam int unsigned HOLD_W = 4;

   // Interrupt controller register offsets
   localparam logic [ADDR_W-1:0] IRQ_INDEX     = 32'h0000_0040;
   localparam logic [ADDR_W-1:0] UNMASK_CLR_LO = 32'h0000_0018;
   localparam logic [ADDR_W-1:0] UNMASK_CLR_HI = 32'h0000_001C;

   // AHB encodings used by this master
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   // Top-level sequencing states
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_IDX_A,
      ST_IDX_D,
      ST_VEC_A,
      ST_VEC_D,
      ST_MSK_A,
      ST_MSK_D,
      ST_PRESENT,
      ST_HOLD
   } irq_state_e;

   // Bus phase of the single-transfer engine
   typedef enum logic [1:0] {
      PH_IDLE,
      PH_ADDR,
      PH_DATA
   } ahb_phase_e;

   // One transfer request from the sequencer to the bus engine
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              write;
   } ahb_req_t;

   // Vector table entry address; 32-bit wrap, carry out of bit 31 dropped
   function automatic logic [ADDR_W-1:0] vtab_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
      return base + ADDR_W'({idx, 2'b00});
   endfunction

   // Sources 0..31 live in the low clear register, 32..63 in the high one
   function automatic logic [ADDR_W-1:0] mask_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
      return base + (idx[IDX_W-1] ? UNMASK_CLR_HI : UNMASK_CLR_LO);
   endfunction

   // One-hot bit of the source within its 32-bit clear register
   function automatic logic [DATA_W-1:0] mask_bit(input logic [IDX_W-1:0] idx);
      return DATA_W'(1) << idx[IDX_W-2:0];
   endfunction

endpackage

// File: rtl/irq_vec_fetch_ahb.sv
// Single, non-pipelined AHB-Lite transfer engine.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   req_c, req         start a transfer (accepted only when the engine is free)
//   haddr/htrans/hwrite/hwdata  registered AHB master outputs
//   hready, hresp      AHB slave handshake
//   aphase_done_c      address phase accepted this cycle
//   done_c, err_c      data phase finished OKAY / with an error response
module ahb_single_master
   import irq_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_c,
   input  ahb_req_t          req,
   input  logic              hready,
   input  logic [1:0]        hresp,
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [DATA_W-1:0] hwdata,
   output logic              aphase_done_c,
   output logic              done_c,
   output logic              err_c
);

   ahb_phase_e        phase_q, phase_d;
   logic [ADDR_W-1:0] haddr_q, haddr_d;
   logic [1:0]        htrans_q, htrans_d;
   logic              hwrite_q, hwrite_d;
   logic [DATA_W-1:0] hwdata_q, hwdata_d;
   logic              err_seen_q, err_seen_d;
   logic              can_issue;

   // Phase register and registered bus outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q    <= PH_IDLE;
         haddr_q    <= '0;
         htrans_q   <= HTRANS_IDLE;
         hwrite_q   <= 1'b0;
         hwdata_q   <= '0;
         err_seen_q <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         haddr_q    <= haddr_d;
         htrans_q   <= htrans_d;
         hwrite_q   <= hwrite_d;
         hwdata_q   <= hwdata_d;
         err_seen_q <= err_seen_d;
      end
   end

   // Phase sequencing; a new request may start in the cycle the previous
   // data phase completes so back-to-back transfers lose no cycle
   always_comb begin
      phase_d       = phase_q;
      haddr_d       = haddr_q;
      htrans_d      = HTRANS_IDLE;
      hwrite_d      = hwrite_q;
      hwdata_d      = hwdata_q;
      err_seen_d    = err_seen_q;
      aphase_done_c = 1'b0;
      done_c        = 1'b0;
      err_c         = 1'b0;
      can_issue     = 1'b0;

      case (phase_q)
         PH_IDLE: begin
            can_issue = 1'b1;
         end
         PH_ADDR: begin
            if (hready) begin
               phase_d       = PH_DATA;
               aphase_done_c = 1'b1;
            end else begin
               htrans_d = HTRANS_NONSEQ;
            end
         end
         PH_DATA: begin
            // Remember an error seen in the first cycle of a two-cycle response
            if (hresp != HRESP_OKAY) begin
               err_seen_d = 1'b1;
            end
            if (hready) begin
               phase_d   = PH_IDLE;
               can_issue = 1'b1;
               if ((hresp != HRESP_OKAY) || err_seen_q) begin
                  err_c = 1'b1;
               end else begin
                  done_c = 1'b1;
               end
            end
         end
         default: begin
            phase_d = PH_IDLE;
         end
      endcase

      if (req_c && can_issue) begin
         phase_d    = PH_ADDR;
         haddr_d    = req.addr;
         htrans_d   = HTRANS_NONSEQ;
         hwrite_d   = req.write;
         hwdata_d   = req.wdata;
         err_seen_d = 1'b0;
      end
   end

   assign haddr  = haddr_q;
   assign htrans = htrans_q;
   assign hwrite = hwrite_q;
   assign hwdata = hwdata_q;

endmodule

// File: rtl/irq_vec_fetch.sv
// Interrupt vector fetch master. On irq_n low it reads the controller's
// index register, fetches the handler vector from the vector table,
// optionally masks the source, and presents the vector to the CPU.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   irq_n                      active-low request from the interrupt controller
//   haddr/htrans/hwrite/hsize/hwdata, hrdata/hready/hresp   AHB-Lite master
//   vec_valid/vec_addr/vec_index, vec_ack                   CPU handshake
//   bus_err                    one-cycle pulse when a bus error aborts a fetch
module irq_vec_fetch
   import irq_pkg::*;
#(
   parameter logic [31:0] INTC_BASE = 32'h0000_0000,
   parameter logic [31:0] VTAB_BASE = 32'h0000_1000,
   parameter bit          AUTO_MASK = 1'b1,
   parameter int unsigned HOLDOFF   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              irq_n,
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [DATA_W-1:0] hwdata,
   input  logic [DATA_W-1:0] hrdata,
   input  logic              hready,
   input  logic [1:0]        hresp,
   output logic              vec_valid,
   output logic [ADDR_W-1:0] vec_addr,
   output logic [IDX_W-1:0]  vec_index,
   input  logic              vec_ack,
   output logic              bus_err
);

   irq_state_e        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [ADDR_W-1:0] vec_addr_q, vec_addr_d;
   logic [IDX_W-1:0]  vec_index_q, vec_index_d;
   logic              vec_valid_q, vec_valid_d;
   logic              bus_err_q, bus_err_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

   logic              req_c;
   ahb_req_t          req;
   logic              aphase_done_c;
   logic              done_c;
   logic              err_c;

   ahb_single_master u_ahb (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_c         (req_c),
      .req           (req),
      .hready        (hready),
      .hresp         (hresp),
      .haddr         (haddr),
      .htrans        (htrans),
      .hwrite        (hwrite),
      .hwdata        (hwdata),
      .aphase_done_c (aphase_done_c),
      .done_c        (done_c),
      .err_c         (err_c)
   );

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         vec_addr_q  <= '0;
         vec_index_q <= '0;
         vec_valid_q <= 1'b0;
         bus_err_q   <= 1'b0;
         hold_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         vec_addr_q  <= vec_addr_d;
         vec_index_q <= vec_index_d;
         vec_valid_q <= vec_valid_d;
         bus_err_q   <= bus_err_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   // Fetch sequencing; each request is issued on the transition into its
   // address-phase state so the bus engine's registered outputs line up
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      vec_addr_d  = vec_addr_q;
      vec_index_d = vec_index_q;
      vec_valid_d = 1'b0;
      bus_err_d   = 1'b0;
      hold_cnt_d  = hold_cnt_q;
      req_c       = 1'b0;
      req         = '0;

      case (state_q)
         ST_IDLE: begin
            if (!irq_n) begin
               req_c    = 1'b1;
               req.addr = INTC_BASE + IRQ_INDEX;
               state_d  = ST_IDX_A;
            end
         end
         ST_IDX_A: begin
            if (aphase_done_c) begin
               state_d = ST_IDX_D;
            end
         end
         ST_IDX_D: begin
            if (err_c) begin
               bus_err_d = 1'b1;
               state_d   = ST_IDLE;
            end else if (done_c) begin
               // Index register is not yet in idx_q; address from read data
               idx_d    = hrdata[IDX_W-1:0];
               req_c    = 1'b1;
               req.addr = vtab_addr(VTAB_BASE, hrdata[IDX_W-1:0]);
               state_d  = ST_VEC_A;
            end
         end
         ST_VEC_A: begin
            if (aphase_done_c) begin
               state_d = ST_VEC_D;
            end
         end
         ST_VEC_D: begin
            if (err_c) begin
               bus_err_d  = 1'b1;
               vec_addr_d = '0;
               state_d    = ST_IDLE;
            end else if (done_c) begin
               vec_addr_d = hrdata;
               if (AUTO_MASK) begin
                  req_c     = 1'b1;
                  req.addr  = mask_addr(INTC_BASE, idx_q);
                  req.wdata = mask_bit(idx_q);
                  req.write = 1'b1;
                  state_d   = ST_MSK_A;
               end else begin
                  vec_valid_d = 1'b1;
                  vec_index_d = idx_q;
                  state_d     = ST_PRESENT;
               end
            end
         end
         ST_MSK_A: begin
            if (aphase_done_c) begin
               state_d = ST_MSK_D;
            end
         end
         ST_MSK_D: begin
            if (err_c) begin
               bus_err_d  = 1'b1;
               vec_addr_d = '0;
               state_d    = ST_IDLE;
            end else if (done_c) begin
               vec_valid_d = 1'b1;
               vec_index_d = idx_q;
               state_d     = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            vec_valid_d = 1'b1;
            if (vec_ack) begin
               vec_valid_d = 1'b0;
               hold_cnt_d  = HOLD_W'(HOLDOFF);
               state_d     = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Let the controller's registered irq_n settle before resampling
            if (hold_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign hsize     = HSIZE_WORD;
   assign vec_valid = vec_valid_q;
   assign vec_addr  = vec_addr_q;
   assign vec_index = vec_index_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_irq_vec_fetch.sv
// Directed bench for irq_vec_fetch with a behavioural AHB slave that models
// the interrupt controller index register and a 64-entry vector table.
module tb_irq_vec_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        irq_n;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic [31:0] hrdata = '0;
   logic        hready = 1'b1;
   logic [1:0]  hresp  = 2'b00;
   logic        vec_valid;
   logic [31:0] vec_addr;
   logic [5:0]  vec_index;
   logic        vec_ack;
   logic        bus_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Slave model state
   logic [31:0] vtab [64];
   logic [5:0]  idx_val = '0;
   int          wait_states = 0;
   bit          err_armed = 1'b0;
   logic [31:0] err_addr = '0;
   bit          dp_active = 1'b0;
   logic [31:0] dp_addr = '0;
   logic        dp_write = 1'b0;
   logic [31:0] dp_wdata = '0;
   bit          dp_err = 1'b0;
   int          wait_left = 0;
   bit          prev_nonseq = 1'b0;
   logic [31:0] prev_addr = '0;
   logic        prev_write = 1'b0;
   logic        prev_hready = 1'b1;
   int          unstable = 0;

   logic [31:0] log_addr  [$];
   logic [31:0] log_wdata [$];
   bit          log_write [$];
   bit          log_err   [$];

   irq_vec_fetch dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq_n     (irq_n),
      .haddr     (haddr),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hwdata    (hwdata),
      .hrdata    (hrdata),
      .hready    (hready),
      .hresp     (hresp),
      .vec_valid (vec_valid),
      .vec_addr  (vec_addr),
      .vec_index (vec_index),
      .vec_ack   (vec_ack),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      if (a == 32'h0000_0040) return 32'hABCD_EF00 | {26'h0, idx_val};
      else if (a >= 32'h0000_1000 && a < 32'h0000_1100) return vtab[a[7:2]];
      else return 32'hDEAD_BEEF;
   endfunction

   // AHB slave: at each falling edge, account for the rising edge just past,
   // then drive hready/hresp/hrdata for the current cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         dp_active   = 1'b0;
         prev_nonseq = 1'b0;
         prev_hready = 1'b1;
         hready      = 1'b1;
         hresp       = 2'b00;
         hrdata      = '0;
      end else begin
         if (dp_active && prev_hready) dp_active = 1'b0;
         if (prev_nonseq && prev_hready) begin
            dp_active = 1'b1;
            dp_addr   = prev_addr;
            dp_write  = prev_write;
            dp_wdata  = hwdata;
            wait_left = wait_states;
            dp_err    = 1'b0;
            if (err_armed && prev_addr == err_addr) begin
               dp_err    = 1'b1;
               err_armed = 1'b0;
               if (wait_left < 1) wait_left = 1;
            end
         end
         hresp  = 2'b00;
         hrdata = '0;
         if (dp_active) begin
            if (haddr !== dp_addr || hwrite !== dp_write || (dp_write && hwdata !== dp_wdata))
               unstable++;
            hresp = dp_err ? 2'b01 : 2'b00;
            if (wait_left > 0) begin
               hready = 1'b0;
               wait_left--;
            end else begin
               hready = 1'b1;
               if (!dp_write) hrdata = rd_word(dp_addr);
               log_addr.push_back(dp_addr);
               log_write.push_back(dp_write);
               log_wdata.push_back(hwdata);
               log_err.push_back(dp_err);
            end
         end else begin
            hready = 1'b1;
         end
         prev_nonseq = (htrans == 2'b10);
         prev_addr   = haddr;
         prev_write  = hwrite;
         prev_hready = hready;
      end
   end

   task automatic clear_log();
      log_addr.delete();
      log_write.delete();
      log_wdata.delete();
      log_err.delete();
   endtask

   // Wait (bounded) for vec_valid; returns rising edges counted, -1 on timeout
   task automatic wait_valid(output int lat);
      lat = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (vec_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic fetch(input logic [5:0] idx, output int lat);
      idx_val = idx;
      clear_log();
      irq_n = 1'b0;
      wait_valid(lat);
   endtask

   task automatic ack_and_idle(input string tag);
      irq_n   = 1'b1;
      vec_ack = 1'b1;
      @(negedge clk);
      vec_ack = 1'b0;
      check_eq({tag, "_valid_drop"}, 32'(vec_valid), 32'd0);
      repeat (8) @(negedge clk);
      check_eq({tag, "_quiet"}, 32'(htrans), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int cnt;
      bit found;
      bit seen_valid;

      for (int i = 0; i < 64; i++) vtab[i] = 32'h0001_0000 + (32'(i) << 8);
      vtab[5] = 32'h0000_2340;
      rst_n   = 1'b0;
      irq_n   = 1'b1;
      vec_ack = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst_htrans",    32'(htrans),    32'd0);
      check_eq("rst_haddr",     haddr,          32'd0);
      check_eq("rst_hwrite",    32'(hwrite),    32'd0);
      check_eq("rst_hwdata",    hwdata,         32'd0);
      check_eq("rst_vec_valid", 32'(vec_valid), 32'd0);
      check_eq("rst_vec_addr",  vec_addr,       32'd0);
      check_eq("rst_vec_index", 32'(vec_index), 32'd0);
      check_eq("rst_bus_err",   32'(bus_err),   32'd0);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("idle_no_irq", 32'(htrans), 32'd0);

      // Zero-wait fetch, index 5
      fetch(6'd5, lat);
      check_eq("t1_latency",   32'(lat),       32'd7);
      check_eq("t1_vec_addr",  vec_addr,       32'h0000_2340);
      check_eq("t1_vec_index", 32'(vec_index), 32'd5);
      check_eq("t1_hsize",     32'(hsize),     32'd2);
      check_eq("t1_ntrans",    32'(log_addr.size()), 32'd3);
      check_eq("t1_idx_addr",  log_addr[0],    32'h0000_0040);
      check_eq("t1_idx_wr",    32'(log_write[0]), 32'd0);
      check_eq("t1_vec_rd",    log_addr[1],    32'h0000_1014);
      check_eq("t1_msk_addr",  log_addr[2],    32'h0000_0018);
      check_eq("t1_msk_wr",    32'(log_write[2]), 32'd1);
      check_eq("t1_msk_data",  log_wdata[2],   32'h0000_0020);
      ack_and_idle("t1");

      // High-half mask, index 37
      fetch(6'd37, lat);
      check_eq("t2_latency",   32'(lat),       32'd7);
      check_eq("t2_vec_rd",    log_addr[1],    32'h0000_1094);
      check_eq("t2_msk_addr",  log_addr[2],    32'h0000_001C);
      check_eq("t2_msk_data",  log_wdata[2],   32'h0000_0020);
      check_eq("t2_vec_addr",  vec_addr,       32'h0001_2500);
      check_eq("t2_vec_index", 32'(vec_index), 32'd37);
      ack_and_idle("t2");

      // Three wait states in every data phase, index 9
      wait_states = 3;
      unstable    = 0;
      fetch(6'd9, lat);
      wait_states = 0;
      check_eq("t3_latency",  32'(lat),      32'd16);
      check_eq("t3_vec_addr", vec_addr,      32'h0001_0900);
      check_eq("t3_stable",   32'(unstable), 32'd0);
      check_eq("t3_msk_addr", log_addr[2],   32'h0000_0018);
      check_eq("t3_msk_data", log_wdata[2],  32'h0000_0200);
      ack_and_idle("t3");

      // Error response on the vector read, index 3, irq_n kept low
      err_armed  = 1'b1;
      err_addr   = 32'h0000_100C;
      idx_val    = 6'd3;
      clear_log();
      irq_n      = 1'b0;
      found      = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (vec_valid) seen_valid = 1'b1;
         if (bus_err) begin
            found = 1'b1;
            break;
         end
      end
      check_eq("t4_err_seen",   32'(found),      32'd1);
      check_eq("t4_no_valid",   32'(seen_valid), 32'd0);
      check_eq("t4_idle_htr",   32'(htrans),     32'd0);
      @(negedge clk);
      check_eq("t4_pulse_w",    32'(bus_err),    32'd0);
      check_eq("t4_retry_htr",  32'(htrans),     32'd2);
      check_eq("t4_retry_addr", haddr,           32'h0000_0040);
      wait_valid(lat);
      check_eq("t4_retry_ok",   32'(lat > 0),    32'd1);
      check_eq("t4_vec_addr",   vec_addr,        32'h0001_0300);
      check_eq("t4_err_addr",   log_addr[1],     32'h0000_100C);
      check_eq("t4_err_flag",   32'(log_err[1]), 32'd1);
      ack_and_idle("t4");

      // Delayed ack with irq_n held low, then holdoff before the next fetch
      fetch(6'd12, lat);
      check_eq("t5_latency", 32'(lat), 32'd7);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (vec_valid && vec_addr == 32'h0001_0C00 && vec_index == 6'd12) cnt++;
      end
      check_eq("t5_held", 32'(cnt), 32'd10);
      vec_ack = 1'b1;
      @(negedge clk);
      vec_ack = 1'b0;
      check_eq("t5_valid_drop", 32'(vec_valid), 32'd0);
      cnt = (htrans == 2'b10) ? 1 : 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (htrans == 2'b10) cnt++;
      end
      check_eq("t5_holdoff", 32'(cnt), 32'd0);
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (htrans == 2'b10) begin
            found = 1'b1;
            break;
         end
      end
      check_eq("t5_restart",      32'(found), 32'd1);
      check_eq("t5_restart_addr", haddr,      32'h0000_0040);
      irq_n = 1'b1;
      wait_valid(lat);
      check_eq("t5_second_idx", 32'(vec_index), 32'd12);
      ack_and_idle("t5");

      // Reset asserted during the mask-write address phase, index 7
      idx_val = 6'd7;
      clear_log();
      irq_n = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (htrans == 2'b10 && haddr == 32'h0000_0018) begin
            found = 1'b1;
            break;
         end
      end
      check_eq("t6_in_msk_a", 32'(found), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t6_htrans",    32'(htrans),    32'd0);
      check_eq("t6_haddr",     haddr,          32'd0);
      check_eq("t6_hwrite",    32'(hwrite),    32'd0);
      check_eq("t6_hwdata",    hwdata,         32'd0);
      check_eq("t6_vec_addr",  vec_addr,       32'd0);
      check_eq("t6_vec_index", 32'(vec_index), 32'd0);
      check_eq("t6_vec_valid", 32'(vec_valid), 32'd0);
      check_eq("t6_bus_err",   32'(bus_err),   32'd0);
      irq_n = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (htrans == 2'b10) cnt++;
      end
      check_eq("t6_waits_irq", 32'(cnt), 32'd0);
      fetch(6'd7, lat);
      check_eq("t6_latency",  32'(lat), 32'd7);
      check_eq("t6_vec_addr2", vec_addr, 32'h0001_0700);
      ack_and_idle("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_vec_fetch.md
Name: irq_vec_fetch

Overview:
- AHB-Lite master that services the interrupt controller's irq_n line on behalf of the CPU.
- When irq_n is low, it reads the controller's irq_index register, then fetches the handler vector from a vector table in memory. If AUTO_MASK=1, it then masks the serviced source through the controller's unmask_clear register.
- It presents the vector to the CPU core with a valid/ack handshake.
- It sits between the processor interrupt input and the system AHB fabric, upstream of the interrupt controller's slave port.

Parameters:
- INTC_BASE, 32'h0000_0000, AHB base address of the interrupt controller.
- VTAB_BASE, 32'h0000_1000, AHB base of the vector table; one 32-bit word per source, 64 entries.
- AUTO_MASK, 1, 1 = mask the serviced source after the vector fetch; 0 = skip the mask write.
- HOLDOFF, 3, cycles to wait after ack before re-sampling irq_n (covers the controller's registered irq_n latency); range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- irq_n  in  1  active-low interrupt request from the controller
- haddr  out  32  AHB address
- htrans  out  2  AHB transfer type; IDLE=2'b00, NONSEQ=2'b10 only
- hwrite  out  1  AHB write
- hsize  out  3  always 3'b010 (word)
- hwdata  out  32  AHB write data
- hrdata  in  32  AHB read data
- hready  in  1  AHB transfer done
- hresp  in  2  AHB response; OKAY=2'b00, anything else is an error
- vec_valid  out  1  vector available to the CPU
- vec_addr  out  32  fetched handler address
- vec_index  out  6  serviced source number
- vec_ack  in  1  CPU accepts the vector
- bus_err  out  1  one-cycle pulse when an AHB error aborts a fetch

Behaviour:
- Reset (rst_n=0, async): all outputs are 0, htrans=IDLE, state=IDLE. A reset mid-transfer drops htrans to IDLE immediately; no retry is performed.
- Bus protocol:
  - Transfers are single and non-pipelined: one address phase (NONSEQ), then data phase(s) with htrans=IDLE.
  - The address phase advances only when hready=1.
  - Data is captured on the first data-phase cycle with hready=1.
  - hwdata is valid throughout the write data phase.
- FSM states: IDLE, IDX_A, IDX_D, VEC_A, VEC_D, MSK_A, MSK_D, PRESENT, HOLD.
  - IDLE: irq_n=0 -> IDX_A.
  - IDX_A: haddr=INTC_BASE+0x40, read. hready=1 -> IDX_D.
  - IDX_D: on hready=1, idx_q <= hrdata[5:0] -> VEC_A.
  - VEC_A: haddr=VTAB_BASE+{idx_q,2'b00}, read -> VEC_D.
  - VEC_D: on hready=1, capture vec_addr <= hrdata -> MSK_A if AUTO_MASK, else PRESENT.
  - MSK_A: haddr=INTC_BASE+(idx_q[5] ? 0x1C : 0x18), write -> MSK_D.
  - MSK_D: hwdata = 32'b1 << idx_q[4:0]; on hready=1 -> PRESENT.
  - PRESENT: vec_valid=1, vec_index=idx_q; vec_addr and vec_index are held stable. vec_ack=1 -> HOLD with vec_valid=0 the next cycle.
  - HOLD: count down from HOLDOFF; at 0 -> IDLE.
- vec_ack while not in PRESENT is ignored.
- Latency with zero-wait-state slaves: irq_n low to vec_valid is 7 cycles with AUTO_MASK=1 and 5 cycles with AUTO_MASK=0.
- Error handling:
  - In any *_D state, hresp!=OKAY makes the block wait for hready=1 (the two-cycle error response), then pulse bus_err for 1 cycle and go to IDLE.
  - vec_valid stays 0 and captured data is discarded.
- irq_n is not re-sampled between IDLE and HOLD completion.
  - irq_n deasserting mid-sequence has no effect.
  - An index read returning 0 with no pending source is still fetched as index 0. The CPU handler tolerates this spurious entry.
- Index wrap: idx_q is 6 bits; the vector address offset is at most 0xFC. Address arithmetic is 32-bit, and carry beyond bit 31 is dropped.
- hsize is always 3'b010. The block issues no BUSY, SEQ or bursts.

Decomposition:
- Shared package irq_pkg:
  - FSM state enum.
  - Interrupt controller register offsets: IRQ_INDEX=0x40, UNMASK_CLR_LO=0x18, UNMASK_CLR_HI=0x1C.
  - HTRANS and HRESP encodings.
- One natural sub-module, ahb_single_master: executes one read or write request with a req/done/err handshake. The FSM sequences it.

Test Plan:
- Zero-wait fetch:
  - Stimulus: irq_n=0, index read returns 5, VTAB[5]=0x0000_2340, AUTO_MASK=1.
  - Response: reads at 0x40 and 0x1014, write of 0x20 to 0x18, then vec_valid=1 with vec_addr=0x2340 and vec_index=5, 7 cycles after irq_n falls.
- High-half mask:
  - Stimulus: index 37.
  - Response: write to INTC_BASE+0x1C with hwdata=0x20; vector read at 0x1094.
- Wait states:
  - Stimulus: slave holds hready=0 for 3 cycles in each data phase.
  - Response: haddr/hwrite/hwdata stay stable; vec_addr is correct; latency is 7+9 cycles.
- Error response:
  - Stimulus: VEC_D receives hresp=ERROR with hready 0 then 1.
  - Response: 1-cycle bus_err pulse, no vec_valid, return to IDLE. If irq_n is still 0, a new IDX_A starts after that.
- Ack and holdoff:
  - Stimulus: vec_ack delayed 10 cycles; irq_n held low.
  - Response: vec_valid is held for 10 cycles; no new address phase for HOLDOFF=3 cycles after ack; then the next sequence starts.
- Reset mid-transfer:
  - Stimulus: assert rst_n=0 during MSK_A.
  - Response: htrans=IDLE immediately, all outputs 0; after release, the block waits for irq_n.
